// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and state encoding for the data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int DMEM_DEPTH = 1024;
    localparam int ADDR_W     = 10;

    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick. The pointer names the preferred requester when both
// are eligible and moves to the other side after every grant unless held.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       hold,
    output logic [1:0] gnt,
    output logic       ptr_nxt
);

    logic       ptr;
    logic [1:0] elig;

    always_comb begin
        elig    = req & mask;
        gnt     = elig;
        if (elig == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
        ptr_nxt = ptr;
        if (!hold && (gnt != 2'b00)) begin
            ptr_nxt = gnt[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester front end for the 1024x32 data memory: round-robin grant,
// locked read-modify-write sequences with timeout, and out-of-range error.
//
// state  | meaning
// ARB    | round-robin between both requesters
// LOCKED | only the owner may be granted; timer counts toward forced release
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = dmem_arbiter_pkg::ADDR_W,
    parameter int LOCK_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_0,
    input  logic        req_1,
    input  logic        we_0,
    input  logic        we_1,
    input  logic        lock_0,
    input  logic        lock_1,
    input  logic [31:0] addr_0,
    input  logic [31:0] addr_1,
    input  logic [31:0] wdata_0,
    input  logic [31:0] wdata_1,
    output logic        gnt_0,
    output logic        gnt_1,
    output logic        rvalid_0,
    output logic        rvalid_1,
    output logic [31:0] rdata_0,
    output logic [31:0] rdata_1,
    output logic        err_0,
    output logic        err_1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wrData,
    output logic        mem_wrMem,
    output logic        mem_rdMem,
    input  logic [31:0] mem_rdData,
    output logic        lock_timeout
);

    state_t             state;
    logic               owner;
    logic [CNT_W-1:0]   timer;

    logic [1:0]         req;
    logic [1:0]         mask;
    logic [1:0]         gnt;
    logic               ptr_nxt;

    logic               sel;
    logic               any_gnt;
    logic               we_s;
    logic               lock_s;
    logic               in_range;
    logic [31:0]        addr_s;
    logic [31:0]        wdata_s;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;

    logic [1:0]         rvalid_q;
    logic [1:0]         err_q;
    logic               unlock;
    logic               expire;

    // Grants are forced low while reset is held so every output reads 0.
    assign req = {req_1, req_0} & {2{rst_n}};

    always_comb begin
        mask = 2'b11;
        if (state == LOCKED) begin
            mask = owner ? 2'b10 : 2'b01;
        end
    end

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mask    (mask),
        .hold    (state == LOCKED),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt)
    );

    assign sel      = gnt[REQ_DBG];
    assign any_gnt  = |gnt;
    assign addr_s   = sel ? addr_1  : addr_0;
    assign wdata_s  = sel ? wdata_1 : wdata_0;
    assign we_s     = sel ? we_1    : we_0;
    assign lock_s   = sel ? lock_1  : lock_0;
    assign in_range = (addr_s[31:ADDR_W] == '0);

    assign gnt_0      = gnt[REQ_CPU];
    assign gnt_1      = gnt[REQ_DBG];
    assign mem_addr   = any_gnt ? addr_s  : addr_q;
    assign mem_wrData = any_gnt ? wdata_s : wdata_q;
    assign mem_wrMem  = any_gnt & in_range & we_s;
    assign mem_rdMem  = any_gnt & in_range & ~we_s;

    assign unlock = (state == LOCKED) && any_gnt && !lock_s;
    assign expire = (state == LOCKED) && (timer == CNT_W'(LOCK_MAX - 1)) && !unlock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB;
            owner        <= 1'b0;
            timer        <= '0;
            lock_timeout <= 1'b0;
            rvalid_q     <= 2'b00;
            err_q        <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            lock_timeout <= 1'b0;
            rvalid_q     <= gnt & {2{~we_s}};
            err_q        <= gnt & {2{~in_range}};
            if (any_gnt) begin
                addr_q  <= addr_s;
                wdata_q <= wdata_s;
            end
            case (state)
                ARB: begin
                    if (any_gnt && lock_s) begin
                        state <= LOCKED;
                        // the pointer has just moved away from the winner
                        owner <= ~ptr_nxt;
                        timer <= '0;
                    end
                end
                LOCKED: begin
                    timer <= timer + 1'b1;
                    if (unlock) begin
                        state <= ARB;
                    end else if (expire) begin
                        state        <= ARB;
                        lock_timeout <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign rvalid_0 = rvalid_q[REQ_CPU];
    assign rvalid_1 = rvalid_q[REQ_DBG];
    assign err_0    = err_q[REQ_CPU];
    assign err_1    = err_q[REQ_DBG];
    assign rdata_0  = (rvalid_q[REQ_CPU] && !err_q[REQ_CPU]) ? mem_rdData : '0;
    assign rdata_1  = (rvalid_q[REQ_DBG] && !err_q[REQ_DBG]) ? mem_rdData : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x32 memory behind it.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_0, req_1, we_0, we_1, lock_0, lock_1;
    logic [31:0] addr_0, addr_1, wdata_0, wdata_1;
    logic        gnt_0, gnt_1, rvalid_0, rvalid_1, err_0, err_1;
    logic [31:0] rdata_0, rdata_1;
    logic [31:0] mem_addr, mem_wrData, mem_rdData;
    logic        mem_wrMem, mem_rdMem, lock_timeout;

    int n_tests;
    int n_fail;

    logic [31:0] mem [0:1023];

    dmem_arbiter #(.ADDR_W(10), .LOCK_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
        .lock_0(lock_0), .lock_1(lock_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1), .err_0(err_0), .err_1(err_1),
        .mem_addr(mem_addr), .mem_wrData(mem_wrData),
        .mem_wrMem(mem_wrMem), .mem_rdMem(mem_rdMem), .mem_rdData(mem_rdData),
        .lock_timeout(lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wrMem) mem[mem_addr[9:0]] <= mem_wrData;
        if (mem_rdMem) mem_rdData <= mem[mem_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_0 = 1'b0; we_0 = 1'b0; lock_0 = 1'b0;
        req_1 = 1'b0; we_1 = 1'b0; lock_1 = 1'b0;
    endtask

    task automatic set0(input logic r, input logic w, input logic l,
                        input logic [31:0] a, input logic [31:0] d);
        req_0 = r; we_0 = w; lock_0 = l; addr_0 = a; wdata_0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l,
                        input logic [31:0] a, input logic [31:0] d);
        req_1 = r; we_1 = w; lock_1 = l; addr_1 = a; wdata_1 = d;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle();
        set0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_gnt_0", gnt_0, 1'b0);
        chk("rst_gnt_1", gnt_1, 1'b0);
        chk("rst_rdmem", mem_rdMem, 1'b0);
        chk("rst_rvalid_0", rvalid_0, 1'b0);
        chk("rst_lock_timeout", lock_timeout, 1'b0);

        // round robin with both requests held
        cyc(); rst_n = 1'b1; #2;
        chk("rr_first_gnt_0", gnt_0, 1'b1);
        chk("rr_first_gnt_1", gnt_1, 1'b0);
        cyc(); #2;
        chk("rr_second_gnt_1", gnt_1, 1'b1);
        chk("rr_second_gnt_0", gnt_0, 1'b0);
        cyc(); #2;
        chk("rr_third_gnt_0", gnt_0, 1'b1);

        // write by cpu then read back by debug port
        cyc(); idle(); set0(1'b1, 1'b1, 1'b0, 32'd5, 32'hDEADBEEF); #2;
        chk("wr_gnt_0", gnt_0, 1'b1);
        chk("wr_wrmem", mem_wrMem, 1'b1);
        chk("wr_addr", mem_addr, 32'd5);
        chk("wr_data", mem_wrData, 32'hDEADBEEF);
        cyc(); idle(); set1(1'b1, 1'b0, 1'b0, 32'd5, 32'h0); #2;
        chk("rd_gnt_1", gnt_1, 1'b1);
        chk("rd_rdmem", mem_rdMem, 1'b1);
        chk("wr_no_rvalid", rvalid_0, 1'b0);
        cyc(); idle(); #2;
        chk("rd_rvalid_1", rvalid_1, 1'b1);
        chk("rd_rdata_1", rdata_1, 32'hDEADBEEF);
        chk("idle_rdmem", mem_rdMem, 1'b0);
        chk("idle_wrmem", mem_wrMem, 1'b0);

        // back-to-back writes, then back-to-back reads with no bubble
        for (int i = 1; i <= 3; i++) begin
            cyc(); idle(); set0(1'b1, 1'b1, 1'b0, 32'(i), 32'hC0DE_0000 | 32'(i)); #2;
        end
        cyc(); idle(); set0(1'b1, 1'b0, 1'b0, 32'd1, 32'h0); #2;
        chk("b2b_gnt_0", gnt_0, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            cyc(); idle();
            if (i <= 3) set0(1'b1, 1'b0, 1'b0, 32'(i), 32'h0);
            #2;
            chk("b2b_rvalid_0", rvalid_0, 1'b1);
            chk("b2b_rdata_0", rdata_0, 32'hC0DE_0000 | 32'(i - 1));
        end

        // out-of-range read
        cyc(); idle(); set1(1'b1, 1'b0, 1'b0, 32'h400, 32'h0); #2;
        chk("oor_gnt_1", gnt_1, 1'b1);
        chk("oor_no_rdmem", mem_rdMem, 1'b0);
        chk("oor_addr", mem_addr, 32'h400);
        cyc(); idle(); #2;
        chk("oor_rvalid_1", rvalid_1, 1'b1);
        chk("oor_err_1", err_1, 1'b1);
        chk("oor_rdata_1", rdata_1, 32'h0);
        cyc(); #2;
        chk("oor_err_pulse", err_1, 1'b0);

        // locked read-modify-write with debug port held
        cyc(); idle(); set0(1'b1, 1'b0, 1'b1, 32'd7, 32'h0); set1(1'b1, 1'b0, 1'b0, 32'd9, 32'h0); #2;
        chk("lock_gnt_0", gnt_0, 1'b1);
        chk("lock_gnt_1", gnt_1, 1'b0);
        cyc(); req_0 = 1'b0; lock_0 = 1'b0; #2;
        chk("lock_block_gnt_1", gnt_1, 1'b0);
        chk("lock_rvalid_0", rvalid_0, 1'b1);
        cyc(); set0(1'b1, 1'b1, 1'b0, 32'd7, 32'h1234_5678); #2;
        chk("unlock_gnt_0", gnt_0, 1'b1);
        chk("unlock_gnt_1", gnt_1, 1'b0);
        chk("unlock_wrmem", mem_wrMem, 1'b1);
        cyc(); idle(); set1(1'b1, 1'b0, 1'b0, 32'd7, 32'h0); #2;
        chk("after_unlock_gnt_1", gnt_1, 1'b1);
        cyc(); idle(); #2;
        chk("rmw_rvalid_1", rvalid_1, 1'b1);
        chk("rmw_rdata_1", rdata_1, 32'h1234_5678);

        // lock timeout: owner walks away
        cyc(); idle(); set0(1'b1, 1'b0, 1'b1, 32'd2, 32'h0); set1(1'b1, 1'b0, 1'b0, 32'd9, 32'h0); #2;
        chk("to_lock_gnt_0", gnt_0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(); req_0 = 1'b0; lock_0 = 1'b0; #2;
            chk("to_held_gnt_1", gnt_1, 1'b0);
            chk("to_held_timeout", lock_timeout, 1'b0);
        end
        cyc(); #2;
        chk("to_pulse", lock_timeout, 1'b1);
        chk("to_gnt_1", gnt_1, 1'b1);
        cyc(); idle(); #2;
        chk("to_pulse_end", lock_timeout, 1'b0);

        // unlock in the terminal cycle beats the timeout
        cyc(); idle(); set0(1'b1, 1'b0, 1'b1, 32'd1, 32'h0); #2;
        chk("ut_lock_gnt_0", gnt_0, 1'b1);
        repeat (3) begin
            cyc(); idle(); #2;
        end
        cyc(); set0(1'b1, 1'b0, 1'b0, 32'd2, 32'h0); set1(1'b1, 1'b0, 1'b0, 32'd9, 32'h0); #2;
        chk("ut_unlock_gnt_0", gnt_0, 1'b1);
        chk("ut_unlock_gnt_1", gnt_1, 1'b0);
        cyc(); idle(); set1(1'b1, 1'b0, 1'b0, 32'd9, 32'h0); #2;
        chk("ut_no_timeout", lock_timeout, 1'b0);
        chk("ut_gnt_1", gnt_1, 1'b1);
        chk("ut_rdata_0", rdata_0, 32'hC0DE_0002);

        // reset in the middle of a locked sequence
        cyc(); idle(); set0(1'b1, 1'b0, 1'b1, 32'd4, 32'h0); set1(1'b1, 1'b0, 1'b0, 32'd9, 32'h0); #2;
        chk("rl_lock_gnt_0", gnt_0, 1'b1);
        cyc(); set0(1'b1, 1'b0, 1'b1, 32'd5, 32'h0); #2;
        chk("rl_owner_gnt_0", gnt_0, 1'b1);
        chk("rl_owner_gnt_1", gnt_1, 1'b0);
        cyc(); rst_n = 1'b0; #2;
        chk("rl_rst_gnt_0", gnt_0, 1'b0);
        chk("rl_rst_rvalid_0", rvalid_0, 1'b0);
        chk("rl_rst_rdmem", mem_rdMem, 1'b0);
        chk("rl_rst_addr", mem_addr, 32'h0);
        cyc(); rst_n = 1'b1; req_0 = 1'b0; lock_0 = 1'b0; #2;
        chk("rl_post_gnt_1", gnt_1, 1'b1);
        chk("rl_post_rvalid_0", rvalid_0, 1'b0);
        cyc(); idle(); #2;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
